// File: rtl/pkt_serializer.sv
// Packet serializer: captures a token, data or handshake packet and emits it
// one bit per consumed cycle (SYNC, PID, fields, CRC), with stall back-pressure.
module pkt_serializer (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        pktready,
  input  logic [3:0]  pid_in,
  input  logic [6:0]  addr_in,
  input  logic [3:0]  endp_in,
  input  logic [63:0] data_in,
  output logic        down_ready,
  input  logic        bit_stall,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        pkt_start,
  output logic        pkt_end
);

  typedef enum logic [2:0] {IDLE, SYNC, PID, TOKEN, DATA, CRC5, CRC16} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt, cnt_nxt;
  logic [3:0]  pid_r;
  logic [6:0]  addr_r;
  logic [3:0]  endp_r;
  logic [63:0] data_r;
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic        consume, field_last;
  logic [6:0]  tok_idx;
  logic [2:0]  crc5_idx;
  logic [7:0]  addr_ext;

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic d);
    logic fb;
    fb = c[4] ^ d;
    return {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  assign down_ready = (state == IDLE);
  assign bit_valid  = (state != IDLE);
  assign consume    = bit_valid & ~bit_stall;
  assign tok_idx    = cnt - 7'd7;
  assign crc5_idx   = 3'd4 - cnt[2:0];
  assign addr_ext   = {1'b0, addr_r};

  always_comb begin
    bit_out    = 1'b0;
    field_last = 1'b0;
    case (state)
      SYNC: begin
        bit_out    = (cnt == 7'd7);
        field_last = (cnt == 7'd7);
      end
      PID: begin
        // low nibble sends pid, high nibble sends its complement
        bit_out    = cnt[2] ? ~pid_r[cnt[1:0]] : pid_r[cnt[1:0]];
        field_last = (cnt == 7'd7);
      end
      TOKEN: begin
        bit_out    = (cnt < 7'd7) ? addr_ext[cnt[2:0]] : endp_r[tok_idx[1:0]];
        field_last = (cnt == 7'd10);
      end
      DATA: begin
        bit_out    = data_r[cnt[5:0]];
        field_last = (cnt == 7'd63);
      end
      CRC5: begin
        bit_out    = ~crc5[crc5_idx];
        field_last = (cnt == 7'd4);
      end
      CRC16: begin
        bit_out    = ~crc16[~cnt[3:0]];
        field_last = (cnt == 7'd15);
      end
      default: ;
    endcase
  end

  assign pkt_start = (state == SYNC) && (cnt == 7'd0);
  assign pkt_end   = field_last &&
                     ((state == CRC5) || (state == CRC16) || ((state == PID) && !pid_r[0]));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == IDLE) begin
      if (pktready) begin
        state_nxt = SYNC;
        cnt_nxt   = '0;
      end
    end else if (consume) begin
      if (field_last) begin
        cnt_nxt = '0;
        case (state)
          SYNC:  state_nxt = PID;
          PID: begin
            if (pid_r[1:0] == 2'b01)      state_nxt = TOKEN;
            else if (pid_r[1:0] == 2'b11) state_nxt = DATA;
            else                          state_nxt = IDLE;
          end
          TOKEN: state_nxt = CRC5;
          DATA:  state_nxt = CRC16;
          default: state_nxt = IDLE;
        endcase
      end else begin
        cnt_nxt = cnt + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      pid_r  <= '0;
      addr_r <= '0;
      endp_r <= '0;
      data_r <= '0;
      crc5   <= '1;
      crc16  <= '1;
    end else if (down_ready && pktready) begin
      pid_r  <= pid_in;
      addr_r <= addr_in;
      endp_r <= endp_in;
      data_r <= data_in;
      crc5   <= '1;
      crc16  <= '1;
    end else if (consume) begin
      // CRCs run over the field bits exactly as they leave on bit_out
      if (state == TOKEN) crc5  <= crc5_step(crc5, bit_out);
      if (state == DATA)  crc16 <= crc16_step(crc16, bit_out);
    end
  end

endmodule

// File: tb/tb_pkt_serializer.sv
// Scoreboard bench for pkt_serializer: stimulus pushes expected bits,
// a negedge monitor pops and compares every consumed bit.
module tb_pkt_serializer;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        pktready = 1'b0;
  logic [3:0]  pid_in = '0;
  logic [6:0]  addr_in = '0;
  logic [3:0]  endp_in = '0;
  logic [63:0] data_in = '0;
  logic        down_ready;
  logic        bit_stall = 1'b0;
  logic        bit_out, bit_valid, pkt_start, pkt_end;

  pkt_serializer dut (
    .clk(clk), .rst_L(rst_L), .pktready(pktready), .pid_in(pid_in),
    .addr_in(addr_in), .endp_in(endp_in), .data_in(data_in),
    .down_ready(down_ready), .bit_stall(bit_stall), .bit_out(bit_out),
    .bit_valid(bit_valid), .pkt_start(pkt_start), .pkt_end(pkt_end)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic b; logic s; logic e; } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int consumed = 0;

  // transmit order: leftmost bit goes first
  localparam logic [31:0] ACK_BITS = 32'b0000000101001011;
  localparam logic [31:0] NAK_BITS = 32'b0000000101011010;
  localparam logic [31:0] OUT_BITS = {8'b00000001, 4'b1000, 4'b0111,
                                      7'b1010100, 4'b0111, 5'b10111};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--)
      q.push_back('{b: bits[i], s: (i == n - 1), e: (i == 0)});
  endtask

  task automatic push_model(input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic [63:0] data);
    logic bl[$];
    logic [4:0]  c5;
    logic [15:0] c16;
    logic        fb;
    for (int i = 0; i < 8; i++) bl.push_back(i == 7);
    for (int i = 0; i < 4; i++) bl.push_back(pid[i]);
    for (int i = 0; i < 4; i++) bl.push_back(~pid[i]);
    if (pid[1:0] == 2'b01) begin
      c5 = 5'b11111;
      for (int i = 0; i < 11; i++) begin
        fb = c5[4] ^ ((i < 7) ? addr[i] : endp[i - 7]);
        c5 = {c5[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        bl.push_back((i < 7) ? addr[i] : endp[i - 7]);
      end
      for (int i = 4; i >= 0; i--) bl.push_back(~c5[i]);
    end else if (pid[1:0] == 2'b11) begin
      c16 = 16'hFFFF;
      for (int i = 0; i < 64; i++) begin
        fb  = c16[15] ^ data[i];
        c16 = {c16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        bl.push_back(data[i]);
      end
      for (int i = 15; i >= 0; i--) bl.push_back(~c16[i]);
    end
    for (int i = 0; i < bl.size(); i++)
      q.push_back('{b: bl[i], s: (i == 0), e: (i == bl.size() - 1)});
  endtask

  always @(negedge clk) begin
    if (rst_L && bit_valid && !bit_stall) begin
      if (q.size() == 0) begin
        check("unexpected_bit", 16'(consumed), 16'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("bit%0d", consumed), 16'({bit_out, pkt_start, pkt_end}),
              16'({e.b, e.s, e.e}));
      end
      consumed++;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!down_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!down_ready) check("idle_timeout", 16'(down_ready), 16'd1);
  endtask

  task automatic accept_pkt(input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic [63:0] data);
    wait_idle();
    pid_in = pid; addr_in = addr; endp_in = endp; data_in = data;
    pktready = 1'b1;
    @(posedge clk); #1;
    pktready = 1'b0;
    check("latency", 16'({bit_valid, pkt_start, down_ready, bit_out}), 16'b1100);
  endtask

  task automatic wait_consumed(input int base, input int n);
    int k = 0;
    while ((consumed - base) < n && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if ((consumed - base) < n) check("consume_timeout", 16'(consumed - base), 16'(n));
  endtask

  initial begin
    int base, cyc;
    logic [4:0] snap;
    #12;
    check("reset_outputs", 16'({down_ready, bit_valid, bit_out, pkt_start, pkt_end}), 16'b10000);
    rst_L = 1'b1;
    @(posedge clk); #1;

    // ACK with exact end timing
    push_bits(ACK_BITS, 16);
    accept_pkt(4'b0010, 7'h00, 4'h0, 64'h0);
    repeat (15) begin @(posedge clk); #1; end
    check("ack_last_bit", 16'({pkt_end, down_ready, bit_valid}), 16'b101);
    @(posedge clk); #1;
    check("ack_idle_c17", 16'({down_ready, bit_valid, bit_out}), 16'b100);

    // OUT token, hand-computed CRC5
    push_bits(OUT_BITS, 32);
    accept_pkt(4'b0001, 7'h15, 4'hE, 64'h0);
    wait_idle();

    // DATA0
    push_model(4'b0011, 7'h00, 4'h0, 64'h0000_0000_AABB_CCDD);
    accept_pkt(4'b0011, 7'h00, 4'h0, 64'h0000_0000_AABB_CCDD);
    wait_idle();

    // stall during PID of OUT token
    base = consumed;
    push_bits(OUT_BITS, 32);
    accept_pkt(4'b0001, 7'h15, 4'hE, 64'h0);
    wait_consumed(base, 10);
    bit_stall = 1'b1;
    snap = {bit_out, pkt_start, pkt_end, bit_valid, down_ready};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall_hold%0d", i),
            16'({bit_out, pkt_start, pkt_end, bit_valid, down_ready}), 16'(snap));
    end
    bit_stall = 1'b0;
    wait_idle();
    check("stall_total", 16'(consumed - base), 16'd32);

    // back-to-back with pktready held and inputs changed mid-packet
    push_model(4'b1001, 7'h3A, 4'h5, 64'h0);
    push_bits(NAK_BITS, 16);
    wait_idle();
    pid_in = 4'b1001; addr_in = 7'h3A; endp_in = 4'h5; data_in = '0;
    pktready = 1'b1;
    @(posedge clk); #1;
    pid_in = 4'b1010; addr_in = 7'h7F; endp_in = 4'h0; data_in = '1;
    cyc = 0;
    while (!down_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_idle_gap", 16'(cyc), 16'd32);
    @(posedge clk); #1;
    pktready = 1'b0;
    check("b2b_second_start", 16'({bit_valid, pkt_start, down_ready}), 16'b110);
    wait_idle();

    // reset mid-DATA at payload bit 40
    base = consumed;
    push_model(4'b1011, 7'h00, 4'h0, 64'h0123_4567_89AB_CDEF);
    accept_pkt(4'b1011, 7'h00, 4'h0, 64'h0123_4567_89AB_CDEF);
    wait_consumed(base, 56);
    #2;
    rst_L = 1'b0;
    q.delete();
    #1;
    check("async_reset", 16'({down_ready, bit_valid, bit_out, pkt_start, pkt_end}), 16'b10000);
    @(posedge clk); @(posedge clk); #1;
    rst_L = 1'b1;
    @(posedge clk); #1;
    check("post_reset_quiet", 16'({down_ready, bit_valid}), 16'b10);
    push_bits(ACK_BITS, 16);
    accept_pkt(4'b0010, 7'h00, 4'h0, 64'h0);
    wait_idle();
    @(posedge clk); #1;

    check("queue_empty", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pkt_serializer.md
PKT_SERIALIZER -- requirements
Module: pkt_serializer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_L  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: pktready  in  1  upstream protocol FSM presents a packet this cycle.
REQ-004 SHALL have: pid_in  in  4  packet PID.
REQ-005 SHALL have: addr_in  in  7  device address (tokens only).
REQ-006 SHALL have: endp_in  in  4  endpoint (tokens only).
REQ-007 SHALL have: data_in  in  64  payload (data packets only).
REQ-008 SHALL have: down_ready  out  1  serializer idle; packet accepted this cycle if pktready.
REQ-009 SHALL have: bit_stall  in  1  downstream bit-stuffer/NRZI stage holds the current bit.
REQ-010 SHALL have: bit_out  out  1  current serial bit.
REQ-011 SHALL have: bit_valid  out  1  bit_out is meaningful.
REQ-012 SHALL have: pkt_start  out  1  bit_out is the first SYNC bit.
REQ-013 SHALL have: pkt_end  out  1  bit_out is the last bit of the packet (EOP follows downstream).

Function
REQ-014 Packet class from pid_in[1:0]: 01 token, 11 data, 10 or 00 handshake.
REQ-015 Bit order SHALL be: SYNC 8'b00000001 (first transmitted bit 0, last 1); PID field pid_in[3:0] then ~pid_in[3:0], LSB first.
REQ-016 Token SHALL then send addr_in LSB first, endp_in LSB first, then CRC5 field MSB first; total 32 bits.
REQ-017 Data SHALL then send data_in[0] through data_in[63], then CRC16 field MSB first; total 96 bits.
REQ-018 Handshake SHALL end after PID; total 16 bits.
REQ-019 CRC5: poly x^5+x^2+1, register preset 5'b11111 at acceptance, updated serially over addr+endp bits in transmit order; transmitted field = ones-complement of final register.
REQ-020 CRC16: poly x^16+x^15+x^2+1, preset 16'hFFFF, updated serially over 64 payload bits; transmitted field = ones-complement.
REQ-021 FSM states SHALL be IDLE, SYNC, PID, TOKEN, DATA, CRC5, CRC16; a bit counter (7 bits) SHALL index the current field.
REQ-022 down_ready SHALL be 1 exactly when state is IDLE (combinational from state).
REQ-023 On pktready & down_ready, pid/addr/endp/data SHALL be captured into internal registers; input changes afterwards SHALL not affect the packet.
REQ-024 pktready while down_ready=0 SHALL be ignored (no queueing).
REQ-025 Latency: packet accepted on edge N; bit_valid=1, pkt_start=1, bit_out=SYNC bit 0 after edge N.
REQ-026 A bit SHALL be consumed on each edge where bit_valid=1 and bit_stall=0; with bit_stall=1, state, counter, CRC and all outputs SHALL hold.
REQ-027 bit_valid SHALL be 1 in every non-IDLE state, 0 in IDLE.
REQ-028 pkt_start/pkt_end SHALL be 1 only with bit_valid=1 on the first/last bit respectively; both SHALL hold with the bit under stall.
REQ-029 After the last bit is consumed, state SHALL be IDLE on the next cycle; a pktready present then SHALL be accepted (one idle cycle minimum between packets).
REQ-030 bit_out SHALL be 0 in IDLE.

Reset
REQ-031 rst_L low SHALL immediately force IDLE, counter 0, CRC registers to preset, captured registers 0; outputs: down_ready=1, bit_valid=0, bit_out=0, pkt_start=0, pkt_end=0.
REQ-032 Reset mid-packet SHALL abandon the packet with no further bits; first packet after release SHALL be accepted normally.

Verification
REQ-033 ACK pid_in=4'b0010, no stall -> 16 valid bits 0000000101001011, pkt_start on bit 1, pkt_end on bit 16, down_ready=1 on cycle 17.
REQ-034 OUT token pid 4'b0001, addr 7'h15, endp 4'hE -> 32 bits; CRC5 field transmitted 1,0,1,1,1; pkt_end on bit 32.
REQ-035 DATA0 pid 4'b0011, data 64'h0000_0000_AABB_CCDD -> 96 bits; payload LSB first; CRC16 field matches bench serial model (preset FFFF, complemented).
REQ-036 bit_stall high 3 cycles during the PID field of a token -> bit_out/pkt flags frozen, no bits lost or duplicated, total 32 consumed bits, CRC unchanged vs no-stall run.
REQ-037 pktready held during busy packet then back-to-back -> second packet accepted only in IDLE cycle after first pkt_end consumed; inputs changed mid-packet do not alter first packet.
REQ-038 rst_L pulsed low at DATA bit 40 -> outputs to reset values asynchronously; next ACK after release serializes correctly.
